// File: rtl/cnu_serial_minsum.sv
// Serial min-sum check-node unit: collects one V2C message per handshake, then
// replays the C2V messages in arrival order.
`timescale 1ns/1ps
module cnu_serial_minsum #(
    parameter int MAG_W  = 4,
    parameter int DEG    = 20,
    parameter int IDX_W  = 5,
    parameter int OFFSET = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [MAG_W-1:0] in_mag,
    input  logic             in_sign,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [MAG_W-1:0] out_mag,
    output logic             out_sign,
    output logic [IDX_W-1:0] out_idx,
    output logic             out_last,
    output logic [IDX_W-1:0] min1_index
);
    typedef enum logic [0:0] {COLLECT = 1'b0, EMIT = 1'b1} state_t;

    localparam logic [MAG_W-1:0] MAG_MAX  = {MAG_W{1'b1}};
    localparam logic [MAG_W-1:0] MAG_ZERO = {MAG_W{1'b0}};
    localparam logic [MAG_W-1:0] OFF_C    = OFFSET[MAG_W-1:0];
    localparam logic [IDX_W-1:0] IDX_ZERO = {IDX_W{1'b0}};
    localparam logic [IDX_W-1:0] IDX_ONE  = {{(IDX_W-1){1'b0}}, 1'b1};
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEG - 1);

    function automatic logic [MAG_W-1:0] sat_sub(input logic [MAG_W-1:0] v);
        if (v > OFF_C) begin
            return v - OFF_C;
        end else begin
            return MAG_ZERO;
        end
    endfunction

    state_t           state_q, state_d;
    logic [MAG_W-1:0] min1_q, min1_d, min2_q, min2_d, mag_sel_s;
    logic [IDX_W-1:0] min1_idx_q, min1_idx_d, cnt_q, cnt_d;
    logic [IDX_W-1:0] out_cnt_q, out_cnt_d, last_idx_q, last_idx_d;
    logic [DEG-1:0]   sign_q, sign_d;
    logic             parity_q, parity_d;

    // State register bank
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= COLLECT;
            min1_q     <= MAG_MAX;
            min2_q     <= MAG_MAX;
            min1_idx_q <= IDX_ZERO;
            cnt_q      <= IDX_ZERO;
            out_cnt_q  <= IDX_ZERO;
            last_idx_q <= IDX_ZERO;
            sign_q     <= {DEG{1'b0}};
            parity_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            min1_q     <= min1_d;
            min2_q     <= min2_d;
            min1_idx_q <= min1_idx_d;
            cnt_q      <= cnt_d;
            out_cnt_q  <= out_cnt_d;
            last_idx_q <= last_idx_d;
            sign_q     <= sign_d;
            parity_q   <= parity_d;
        end
    end

    // Next-state: min1/min2 tracking while collecting, output sequencing while emitting
    always_comb begin
        state_d    = state_q;
        min1_d     = min1_q;
        min2_d     = min2_q;
        min1_idx_d = min1_idx_q;
        cnt_d      = cnt_q;
        out_cnt_d  = out_cnt_q;
        last_idx_d = last_idx_q;
        sign_d     = sign_q;
        parity_d   = parity_q;
        case (state_q)
            COLLECT: begin
                if (in_valid) begin
                    sign_d[cnt_q] = in_sign;
                    parity_d      = parity_q ^ in_sign;
                    // Strict compare keeps the earliest index on ties
                    if (in_mag < min1_q) begin
                        min2_d     = min1_q;
                        min1_d     = in_mag;
                        min1_idx_d = cnt_q;
                    end else if (in_mag < min2_q) begin
                        min2_d = in_mag;
                    end else begin
                        min2_d = min2_q;
                    end
                    if (in_last || (cnt_q == LAST_IDX)) begin
                        last_idx_d = cnt_q;
                        out_cnt_d  = IDX_ZERO;
                        state_d    = EMIT;
                    end else begin
                        cnt_d = cnt_q + IDX_ONE;
                    end
                end else begin
                    state_d = COLLECT;
                end
            end
            EMIT: begin
                if (out_ready) begin
                    if (out_cnt_q == last_idx_q) begin
                        min1_d     = MAG_MAX;
                        min2_d     = MAG_MAX;
                        min1_idx_d = IDX_ZERO;
                        parity_d   = 1'b0;
                        cnt_d      = IDX_ZERO;
                        state_d    = COLLECT;
                    end else begin
                        out_cnt_d = out_cnt_q + IDX_ONE;
                    end
                end else begin
                    state_d = EMIT;
                end
            end
            default: begin
                state_d = COLLECT;
            end
        endcase
    end

    // C2V outputs decoded from registered state only; forced to zero outside EMIT
    always_comb begin
        mag_sel_s = (out_cnt_q == min1_idx_q) ? min2_q : min1_q;
        if (state_q == EMIT) begin
            out_valid = 1'b1;
            out_mag   = sat_sub(mag_sel_s);
            out_sign  = parity_q ^ sign_q[out_cnt_q];
            out_idx   = out_cnt_q;
            out_last  = (out_cnt_q == last_idx_q);
        end else begin
            out_valid = 1'b0;
            out_mag   = MAG_ZERO;
            out_sign  = 1'b0;
            out_idx   = IDX_ZERO;
            out_last  = 1'b0;
        end
    end

    assign in_ready   = (state_q == COLLECT);
    assign min1_index = min1_idx_q;

endmodule

// File: tb/tb_cnu_serial_minsum.sv
// Bench for cnu_serial_minsum: two instances (OFFSET 0 and 1) share stimulus and
// are checked against an exclude-self min/xor reference computed per output edge.
`timescale 1ns/1ps
module tb_cnu_serial_minsum;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0, in_sign = 1'b0, in_last = 1'b0, out_ready = 1'b1;
    logic [3:0] in_mag = 4'd0;
    logic       in_ready_s [2];
    logic       out_valid_s[2];
    logic [3:0] out_mag_s  [2];
    logic       out_sign_s [2];
    logic [4:0] out_idx_s  [2];
    logic       out_last_s [2];
    logic [4:0] min1_idx_s [2];

    int ncmp = 0;
    int nerr = 0;
    int row_mag[32];
    int row_sgn[32];
    int row_n = 0;

    cnu_serial_minsum #(.MAG_W(4), .DEG(20), .IDX_W(5), .OFFSET(0)) u0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_s[0]),
        .in_mag(in_mag), .in_sign(in_sign), .in_last(in_last),
        .out_valid(out_valid_s[0]), .out_ready(out_ready), .out_mag(out_mag_s[0]),
        .out_sign(out_sign_s[0]), .out_idx(out_idx_s[0]), .out_last(out_last_s[0]),
        .min1_index(min1_idx_s[0]));

    cnu_serial_minsum #(.MAG_W(4), .DEG(20), .IDX_W(5), .OFFSET(1)) u1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_s[1]),
        .in_mag(in_mag), .in_sign(in_sign), .in_last(in_last),
        .out_valid(out_valid_s[1]), .out_ready(out_ready), .out_mag(out_mag_s[1]),
        .out_sign(out_sign_s[1]), .out_idx(out_idx_s[1]), .out_last(out_last_s[1]),
        .min1_index(min1_idx_s[1]));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference: each output edge sees the minimum of all other magnitudes.
    function automatic int exp_mag(input int i, input int off);
        int m = 15;
        for (int j = 0; j < row_n; j++) if (j != i && row_mag[j] < m) m = row_mag[j];
        return (m > off) ? m - off : 0;
    endfunction

    function automatic int exp_sign(input int i);
        int s = 0;
        for (int j = 0; j < row_n; j++) if (j != i) s ^= row_sgn[j];
        return s;
    endfunction

    function automatic int exp_min1();
        int k = 0;
        for (int j = 1; j < row_n; j++) if (row_mag[j] < row_mag[k]) k = j;
        return k;
    endfunction

    task automatic chk_idle(input string tag);
        for (int u = 0; u < 2; u++) begin
            chk($sformatf("%s.u%0d.in_ready", tag, u), in_ready_s[u], 1);
            chk($sformatf("%s.u%0d.out_valid", tag, u), out_valid_s[u], 0);
        end
    endtask

    task automatic send(input bit use_last, input int n);
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1;
            in_mag   = row_mag[i][3:0];
            in_sign  = row_sgn[i][0];
            in_last  = use_last && (i == n - 1);
            chk_idle($sformatf("in%0d", i));
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // Drain one row; optional 3-cycle stall at stall_idx, random backpressure, or reset at rst_idx.
    task automatic recv(input bit rand_bp, input int stall_idx, input int rst_idx);
        int i = 0;
        int budget = 0;
        int stalls = 0;
        while (i < row_n && budget < 400) begin
            if (i == rst_idx) begin
                rst_n = 1'b0;
                #2;
                for (int u = 0; u < 2; u++) begin
                    chk($sformatf("rst.u%0d.out_valid", u), out_valid_s[u], 0);
                    chk($sformatf("rst.u%0d.out_mag", u), out_mag_s[u], 0);
                    chk($sformatf("rst.u%0d.min1_index", u), min1_idx_s[u], 0);
                end
                @(posedge clk); #1;
                chk_idle("rst_hold");
                rst_n = 1'b1;
                @(posedge clk); #1;
                chk_idle("rst_post");
                out_ready = 1'b1;
                return;
            end
            if (i == stall_idx && stalls < 3) begin
                out_ready = 1'b0;
                stalls++;
            end else begin
                out_ready = rand_bp ? 1'($urandom_range(0, 1)) : 1'b1;
            end
            for (int u = 0; u < 2; u++) begin
                chk($sformatf("u%0d.valid[%0d]", u, i), out_valid_s[u], 1);
                chk($sformatf("u%0d.in_ready[%0d]", u, i), in_ready_s[u], 0);
                chk($sformatf("u%0d.mag[%0d]", u, i), out_mag_s[u], exp_mag(i, u));
                chk($sformatf("u%0d.sign[%0d]", u, i), out_sign_s[u], exp_sign(i));
                chk($sformatf("u%0d.idx[%0d]", u, i), out_idx_s[u], i);
                chk($sformatf("u%0d.last[%0d]", u, i), out_last_s[u], (i == row_n - 1) ? 1 : 0);
                chk($sformatf("u%0d.min1_index[%0d]", u, i), min1_idx_s[u], exp_min1());
            end
            @(posedge clk); #1;
            budget++;
            if (out_ready) i++;
        end
        chk("recv_budget", (budget < 400) ? 1 : 0, 1);
        out_ready = 1'b1;
    endtask

    initial begin
        int tp[20] = '{3, 1, 12, 7, 2, 11, 10, 2, 4, 9, 10, 5, 4, 3, 8, 7, 9, 10, 12, 15};
        // reset values
        repeat (2) @(posedge clk);
        #1;
        for (int u = 0; u < 2; u++) begin
            chk($sformatf("reset.u%0d.in_ready", u), in_ready_s[u], 1);
            chk($sformatf("reset.u%0d.out_valid", u), out_valid_s[u], 0);
            chk($sformatf("reset.u%0d.out_mag", u), out_mag_s[u], 0);
            chk($sformatf("reset.u%0d.out_sign", u), out_sign_s[u], 0);
            chk($sformatf("reset.u%0d.out_idx", u), out_idx_s[u], 0);
            chk($sformatf("reset.u%0d.out_last", u), out_last_s[u], 0);
            chk($sformatf("reset.u%0d.min1_index", u), min1_idx_s[u], 0);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;

        // full-degree row, sign only on edge 0
        row_n = 20;
        for (int i = 0; i < 20; i++) begin row_mag[i] = tp[i]; row_sgn[i] = (i == 0) ? 1 : 0; end
        send(1'b1, 20); recv(1'b0, -1, -1); chk_idle("row_a_done");

        // tie row
        row_n = 3; row_mag[0] = 5; row_mag[1] = 5; row_mag[2] = 9;
        for (int i = 0; i < 3; i++) row_sgn[i] = 0;
        send(1'b1, 3); recv(1'b0, -1, -1);

        // offset saturation row
        row_n = 2; row_mag[0] = 0; row_mag[1] = 3; row_sgn[0] = 1; row_sgn[1] = 0;
        send(1'b1, 2); recv(1'b0, -1, -1);

        // degree 1
        row_n = 1; row_mag[0] = 6; row_sgn[0] = 1;
        send(1'b1, 1); recv(1'b0, -1, -1);

        // 21 beats without in_last: row closes after 20, 21st beat held and ignored
        row_n = 20;
        for (int i = 0; i < 21; i++) begin row_mag[i] = $urandom_range(0, 15); row_sgn[i] = $urandom_range(0, 1); end
        send(1'b0, 20);
        in_valid = 1'b1; in_mag = row_mag[20][3:0]; in_sign = 1'b1;
        chk("beat21.in_ready", in_ready_s[0], 0);
        recv(1'b0, -1, -1);
        in_valid = 1'b0;
        chk_idle("after21");

        // backpressure stall at idx2
        row_n = 8;
        for (int i = 0; i < 8; i++) begin row_mag[i] = $urandom_range(0, 15); row_sgn[i] = $urandom_range(0, 1); end
        send(1'b1, 8); recv(1'b0, 2, -1);

        // reset at idx4 of EMIT, then a clean 2-beat row
        send(1'b1, 8); recv(1'b0, -1, 4);
        row_n = 2; row_mag[0] = 7; row_mag[1] = 4; row_sgn[0] = 0; row_sgn[1] = 1;
        send(1'b1, 2); recv(1'b0, -1, -1);

        // random rows with random backpressure
        for (int r = 0; r < 6; r++) begin
            row_n = $urandom_range(1, 20);
            for (int i = 0; i < row_n; i++) begin row_mag[i] = $urandom_range(0, 15); row_sgn[i] = $urandom_range(0, 1); end
            send(1'b1, row_n); recv(1'b1, -1, -1);
        end
        chk_idle("final");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end
endmodule
